// File: rtl/toast_imem_responder_pkg.sv
// rtl/toast_imem_responder_pkg.sv - shared constants and FSM state type for the IMEM responder
package toast_imem_responder_pkg;

  localparam int          IMEM_DEPTH_DEFAULT = 1024;
  localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/toast_imem_ram.sv
// rtl/toast_imem_ram.sv - 1R1W synchronous RAM with registered read, storage not reset
module toast_imem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read; a same-word read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/toast_imem_responder.sv
// rtl/toast_imem_responder.sv - IF-side instruction memory with streaming boot-load port
module toast_imem_responder
  import toast_imem_responder_pkg::*;
#(
  parameter int                        REG_DATA_WIDTH  = 32,
  parameter int                        IMEM_ADDR_WIDTH = 32,
  parameter int                        IMEM_DEPTH      = IMEM_DEPTH_DEFAULT,
  parameter logic [REG_DATA_WIDTH-1:0] NOP_INSTR       = NOP_INSTR_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic [IMEM_ADDR_WIDTH-1:0]    IMEM_addr_i,
  output logic [REG_DATA_WIDTH-1:0]     IMEM_data_o,
  output logic                          IMEM_fault_o,
  input  logic                          load_start_i,
  input  logic [IMEM_ADDR_WIDTH-1:0]    load_base_i,
  input  logic [$clog2(IMEM_DEPTH):0]   load_len_i,
  input  logic                          load_valid_i,
  input  logic [REG_DATA_WIDTH-1:0]     load_data_i,
  output logic                          load_ready_o,
  output logic                          load_done_o,
  output logic                          load_err_o,
  output logic                          imem_busy_o
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int LW = AW + 1;

  state_t                     state_q;
  logic [IMEM_ADDR_WIDTH-3:0] base_q;
  logic [LW-1:0]              len_q;
  logic [LW-1:0]              cnt_q;
  logic                       nop_q;

  logic [AW-1:0]              rd_addr;
  logic [REG_DATA_WIDTH-1:0]  rd_data;
  logic                       fetch_fault;
  logic [IMEM_ADDR_WIDTH-1:0] wr_sum;
  logic                       wr_wrap;
  logic                       wr_en;
  logic                       last_word;

  assign rd_addr     = IMEM_addr_i[AW+1:2];
  assign fetch_fault = (IMEM_addr_i[1:0] != 2'b00) ||
                       ((IMEM_addr_i >> 2) >= IMEM_ADDR_WIDTH'(IMEM_DEPTH));

  // Word address of the current load beat; anything at or past the depth wraps.
  assign wr_sum    = {2'b00, base_q} + IMEM_ADDR_WIDTH'(cnt_q);
  assign wr_wrap   = wr_sum >= IMEM_ADDR_WIDTH'(IMEM_DEPTH);
  assign wr_en     = (state_q == LOAD) && load_valid_i && load_ready_o;
  assign last_word = (cnt_q == len_q - LW'(1));

  toast_imem_ram #(
    .DATA_WIDTH (REG_DATA_WIDTH),
    .DEPTH      (IMEM_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_sum[AW-1:0]),
    .wr_data (load_data_i)
  );

  // The RAM read register is unreset, so a flag registered with it selects NOP instead.
  assign IMEM_data_o = nop_q ? NOP_INSTR : rd_data;

  // Fetch qualifiers: faults and busy cycles force NOP; busy masks the fault flag.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      nop_q        <= 1'b1;
      IMEM_fault_o <= 1'b0;
    end else begin
      nop_q        <= imem_busy_o | fetch_fault;
      IMEM_fault_o <= fetch_fault & ~imem_busy_o;
    end
  end

  // Boot-load FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      load_ready_o <= 1'b0;
      load_done_o  <= 1'b0;
      load_err_o   <= 1'b0;
      imem_busy_o  <= 1'b0;
    end else begin
      load_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start_i) begin
            load_err_o <= (load_base_i[1:0] != 2'b00);
            if (load_len_i != '0) begin
              base_q       <= load_base_i[IMEM_ADDR_WIDTH-1:2];
              len_q        <= load_len_i;
              cnt_q        <= '0;
              load_ready_o <= 1'b1;
              imem_busy_o  <= 1'b1;
              state_q      <= LOAD;
            end else begin
              load_done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            cnt_q <= cnt_q + LW'(1);
            if (wr_wrap) begin
              load_err_o <= 1'b1;
            end
            if (last_word) begin
              load_ready_o <= 1'b0;
              load_done_o  <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          imem_busy_o <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          load_ready_o <= 1'b0;
          imem_busy_o  <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toast_imem_responder.sv
// tb/tb_toast_imem_responder.sv - directed self-checking bench for toast_imem_responder
module tb_toast_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_fault;
  logic        load_start;
  logic [31:0] load_base;
  logic [10:0] load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic        imem_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_words [8];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_fault;
  } fetch_vec_t;

  fetch_vec_t vecs [13];

  toast_imem_responder dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .IMEM_addr_i  (imem_addr),
    .IMEM_data_o  (imem_data),
    .IMEM_fault_o (imem_fault),
    .load_start_i (load_start),
    .load_base_i  (load_base),
    .load_len_i   (load_len),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .load_done_o  (load_done),
    .load_err_o   (load_err),
    .imem_busy_o  (imem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic exp_f);
    imem_addr = addr;
    step();
    chk({name, "_data"}, imem_data, exp_d);
    chk({name, "_fault"}, {31'd0, imem_fault}, {31'd0, exp_f});
  endtask

  // Runs a complete load from ld_words; a misaligned fetch address is held to show busy masking.
  task automatic do_load(input logic [31:0] base, input int len, input bit gap);
    int  idx;
    bit  done_seen;
    bit  hs;
    idx       = 0;
    done_seen = 0;
    imem_addr = 32'h6;
    load_start = 1'b1;
    load_base  = base;
    load_len   = 11'(len);
    step();
    load_start = 1'b0;
    chk("busy_after_start", {31'd0, imem_busy}, 32'd1);
    chk("ready_after_start", {31'd0, load_ready}, 32'd1);
    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      load_valid = (!gap || (cyc % 2 == 1)) && (idx < len);
      load_data  = ld_words[idx % 8];
      hs = load_valid && load_ready;
      step();
      if (hs) idx++;
      if (load_done) done_seen = 1;
      else chk("busy_in_load", {31'd0, imem_busy}, 32'd1);
    end
    load_valid = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got no load_done expected pulse within 100 cycles");
    end else begin
      chk("handshakes", idx, len);
      chk("busy_in_done", {31'd0, imem_busy}, 32'd1);
      chk("ready_in_done", {31'd0, load_ready}, 32'd0);
      chk("masked_fault", {31'd0, imem_fault}, 32'd0);
      chk("masked_data", imem_data, NOP);
      step();
      chk("done_one_cycle", {31'd0, load_done}, 32'd0);
      chk("busy_after_done", {31'd0, imem_busy}, 32'd0);
      chk("masked_data_last", imem_data, NOP);
    end
  endtask

  initial begin
    vecs[0]  = '{"f_0x0",    32'h0000_0000, 32'h1000_0001, 1'b0};
    vecs[1]  = '{"f_0x4",    32'h0000_0004, 32'h1000_0002, 1'b0};
    vecs[2]  = '{"f_0x8",    32'h0000_0008, 32'h1000_0003, 1'b0};
    vecs[3]  = '{"f_0xc",    32'h0000_000C, 32'h1000_0004, 1'b0};
    vecs[4]  = '{"f_0x10",   32'h0000_0010, 32'h0000_000A, 1'b0};
    vecs[5]  = '{"f_0x14",   32'h0000_0014, 32'h0000_000B, 1'b0};
    vecs[6]  = '{"f_0x18",   32'h0000_0018, 32'h0000_000C, 1'b0};
    vecs[7]  = '{"f_mis6",   32'h0000_0006, NOP,           1'b1};
    vecs[8]  = '{"f_depth",  32'h0000_1000, NOP,           1'b1};
    vecs[9]  = '{"f_mis2",   32'h0000_0002, NOP,           1'b1};
    vecs[10] = '{"f_high",   32'hFFFF_FFFC, NOP,           1'b1};
    vecs[11] = '{"f_mis1",   32'h0000_0001, NOP,           1'b1};
    vecs[12] = '{"f_again",  32'h0000_0018, 32'h0000_000C, 1'b0};

    resetn     = 1'b0;
    imem_addr  = 32'h0;
    load_start = 1'b0;
    load_base  = 32'h0;
    load_len   = 11'd0;
    load_valid = 1'b0;
    load_data  = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_data", imem_data, NOP);
    chk("rst_fault", {31'd0, imem_fault}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_busy", {31'd0, imem_busy}, 32'd0);
    resetn = 1'b1;
    step();

    // Ungapped load at base 0, then gapped load at 0x10
    ld_words[0] = 32'h1000_0001; ld_words[1] = 32'h1000_0002;
    ld_words[2] = 32'h1000_0003; ld_words[3] = 32'h1000_0004;
    do_load(32'h0, 4, 1'b0);
    ld_words[0] = 32'hA; ld_words[1] = 32'hB; ld_words[2] = 32'hC;
    do_load(32'h10, 3, 1'b1);
    chk("err_aligned", {31'd0, load_err}, 32'd0);

    // Back-to-back fetch table
    for (int i = 0; i < 13; i++) begin
      fetch_chk(vecs[i].name, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault);
    end

    // Wrap-around load across the top of memory
    ld_words[0] = 32'h11; ld_words[1] = 32'h22;
    do_load(32'hFFC, 2, 1'b0);
    chk("wrap_err", {31'd0, load_err}, 32'd1);
    fetch_chk("wrap_top", 32'hFFC, 32'h11, 1'b0);
    fetch_chk("wrap_zero", 32'h0, 32'h22, 1'b0);
    chk("wrap_err_sticky", {31'd0, load_err}, 32'd1);

    // Zero-length start: done next cycle, no busy, clears error
    load_start = 1'b1;
    load_base  = 32'h0;
    load_len   = 11'd0;
    step();
    load_start = 1'b0;
    chk("len0_done", {31'd0, load_done}, 32'd1);
    chk("len0_busy", {31'd0, imem_busy}, 32'd0);
    chk("len0_err_clr", {31'd0, load_err}, 32'd0);
    step();
    chk("len0_done_end", {31'd0, load_done}, 32'd0);
    chk("len0_busy_end", {31'd0, imem_busy}, 32'd0);

    // Misaligned base: error set, low bits dropped
    ld_words[0] = 32'h99;
    do_load(32'h22, 1, 1'b0);
    chk("mis_err", {31'd0, load_err}, 32'd1);
    fetch_chk("mis_word", 32'h20, 32'h99, 1'b0);

    // Start pulse during LOAD is ignored
    load_start = 1'b1;
    load_base  = 32'h40;
    load_len   = 11'd2;
    step();
    load_start = 1'b0;
    chk("start_clr_err", {31'd0, load_err}, 32'd0);
    load_valid = 1'b1;
    load_data  = 32'h55;
    step();
    load_valid = 1'b0;
    load_start = 1'b1;
    load_base  = 32'h80;
    load_len   = 11'd5;
    step();
    load_start = 1'b0;
    chk("ign_busy", {31'd0, imem_busy}, 32'd1);
    chk("ign_done", {31'd0, load_done}, 32'd0);
    load_valid = 1'b1;
    load_data  = 32'h66;
    step();
    load_valid = 1'b0;
    chk("ign_done_pulse", {31'd0, load_done}, 32'd1);
    step();
    fetch_chk("ign_w0", 32'h40, 32'h55, 1'b0);
    fetch_chk("ign_w1", 32'h44, 32'h66, 1'b0);

    // Reset in the middle of a 5-word load
    load_start = 1'b1;
    load_base  = 32'h101;
    load_len   = 11'd5;
    step();
    load_start = 1'b0;
    chk("mid_err_set", {31'd0, load_err}, 32'd1);
    load_valid = 1'b1;
    load_data  = 32'hD0;
    step();
    load_data  = 32'hD1;
    step();
    load_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_data", imem_data, NOP);
    chk("mid_rst_fault", {31'd0, imem_fault}, 32'd0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, load_done}, 32'd0);
    chk("mid_rst_err", {31'd0, load_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, imem_busy}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();
    fetch_chk("mid_keep0", 32'h100, 32'hD0, 1'b0);
    fetch_chk("mid_keep1", 32'h104, 32'hD1, 1'b0);
    ld_words[0] = 32'h77;
    do_load(32'h108, 1, 1'b0);
    chk("post_rst_err", {31'd0, load_err}, 32'd0);
    fetch_chk("post_rst_word", 32'h108, 32'h77, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toast_imem_responder.md
Name: toast_imem_responder

Overview:
Instruction-memory responder on the IMEM side of the IF fetch interface. It accepts the byte address driven by the IF stage and returns the 32-bit instruction word one cycle later from a single-port-read / single-port-write RAM. A streaming boot-load port fills the RAM through a valid/ready handshake. While a load is in progress, `imem_busy_o` holds the core in stall and fetches return NOP.

Parameters:
- REG_DATA_WIDTH, 32, instruction/data word width.
- IMEM_ADDR_WIDTH, 32, byte-address width of the fetch and load-base ports.
- IMEM_DEPTH, 1024, RAM depth in words; must be a power of 2.
- NOP_INSTR, 32'h0000_0013, word returned on reset, fault or busy (addi x0,x0,0).

Ports:
- clk_i  in  1  clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- IMEM_addr_i  in  IMEM_ADDR_WIDTH  fetch byte address from the IF stage.
- IMEM_data_o  out  REG_DATA_WIDTH  fetched instruction, registered.
- IMEM_fault_o  out  1  registered alongside IMEM_data_o; fetch was misaligned or out of range.
- load_start_i  in  1  one-cycle pulse that begins a boot load; ignored unless in IDLE.
- load_base_i  in  IMEM_ADDR_WIDTH  byte address of the first word; sampled with load_start_i.
- load_len_i  in  $clog2(IMEM_DEPTH)+1  word count; sampled with load_start_i.
- load_valid_i  in  1  load word valid.
- load_data_i  in  REG_DATA_WIDTH  load word.
- load_ready_o  out  1  responder accepts a word this cycle.
- load_done_o  out  1  one-cycle pulse at load completion.
- load_err_o  out  1  sticky load error; cleared by the next accepted load_start_i.
- imem_busy_o  out  1  load in progress; the core must stall.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0, IMEM_data_o=NOP_INSTR.
  - IMEM_fault_o, load_ready_o, load_done_o, load_err_o and imem_busy_o all 0.
  - RAM contents are not reset.
- Fetch, registered with 1-cycle latency:
  - At each posedge, IMEM_data_o <= mem[IMEM_addr_i[$clog2(IMEM_DEPTH)+1:2]].
  - fault = (IMEM_addr_i[1:0]!=0) or (IMEM_addr_i>>2 >= IMEM_DEPTH).
  - On fault: IMEM_data_o <= NOP_INSTR and IMEM_fault_o <= 1.
  - While imem_busy_o is asserted: IMEM_data_o <= NOP_INSTR and IMEM_fault_o <= 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start_i with load_len_i!=0: latch base word = load_base_i>>2, latch len, counter=0, clear load_err_o, go to LOAD.
  - load_start_i with load_len_i==0: load_done_o pulses the next cycle; stay IDLE; load_err_o is cleared.
  - Misaligned load_base_i sets load_err_o; bits [1:0] are ignored and the load proceeds.
- LOAD:
  - imem_busy_o=1, load_ready_o=1.
  - Handshake = load_valid_i & load_ready_o. Per handshake: write mem[(base+counter) mod IMEM_DEPTH] = load_data_i, then counter++.
  - Wrap-around: if base+counter >= IMEM_DEPTH, the write wraps and load_err_o is set (sticky); the load continues.
  - The handshake with counter==len-1 moves the FSM to DONE.
  - load_valid_i low: hold state and wait; no timeout.
  - load_start_i in LOAD or DONE is ignored.
- DONE, one cycle:
  - load_done_o=1, load_ready_o=0.
  - imem_busy_o stays 1 so the final write is visible before the first post-load fetch.
  - Next state is IDLE.
- Read-during-write to the same word returns the old data. This case is unreachable because fetch is masked by busy.
- Reset mid-load: the FSM returns to IDLE and the partial RAM contents remain.
- Maximum load_len_i = IMEM_DEPTH; a full-depth load with base 0 wraps nowhere.

Decomposition:
- toast_definitions.vh holds:
  - NOP_INSTR constant.
  - FSM state localparams (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
  - IMEM_DEPTH default.
- Sub-module toast_imem_ram: 1R1W synchronous RAM, registered read, no reset on storage.
- FSM, fault logic and NOP muxing stay in the top level.

Test Plan:
1. Reset, then fetch 0x0 with no load -> IMEM_data_o=0x00000013 and IMEM_fault_o=0 during reset; afterwards the data equals the RAM preset of the bench backdoor one cycle after the address.
2. Load base=0x10, len=3, words 0xA,0xB,0xC with load_valid_i gapped on alternate cycles:
   - Expect 3 handshakes, load_done_o pulse, imem_busy_o high from the cycle after start through DONE.
   - Then fetch 0x10/0x14/0x18 back-to-back -> 0xA/0xB/0xC with 1-cycle latency.
3. Fetch 0x6 -> IMEM_fault_o=1, data=NOP. Fetch IMEM_DEPTH*4 -> fault=1, data=NOP.
4. Load base=(IMEM_DEPTH-1)*4, len=2, words 0x11,0x22 -> mem[DEPTH-1]=0x11, mem[0]=0x22; load_err_o=1 until the next start.
5. load_len_i=0 -> load_done_o pulses after 1 cycle, imem_busy_o never rises. Then assert load_start_i while in LOAD -> ignored, count unchanged.
6. Assert resetn_i low after 2 of 5 words -> all outputs at reset values immediately (async); the first 2 words remain in RAM; the FSM accepts a new start in IDLE.
